// File: rtl/phi2_bus_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phi2_bus_responder_pkg
// Description : Shared types and constants for the phi_2 bus responder:
//               FSM state encoding, counter width, parameter bounds and the
//               FDC register map seen by the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
package phi2_bus_responder_pkg;

    // Bus-cycle states, explicitly 3-bit encoded
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_RD_DRIVE = 3'd2,
        ST_WR_WAIT  = 3'd3,
        ST_HOLD     = 3'd4
    } bus_state_e;

    // Latency and hold counters share one width
    localparam int unsigned c_cnt_w = 4;

    // Legal ranges for the timing parameters
    localparam int c_rd_latency_min  = 1;
    localparam int c_rd_latency_max  = 15;
    localparam int c_hold_cycles_min = 0;
    localparam int c_hold_cycles_max = 15;

    // FDC register map (CPU-visible offsets), shared with the FDC core
    localparam logic [3:0] c_fdc_reg_sra  = 4'h0;
    localparam logic [3:0] c_fdc_reg_srb  = 4'h1;
    localparam logic [3:0] c_fdc_reg_dor  = 4'h2;
    localparam logic [3:0] c_fdc_reg_tdr  = 4'h3;
    localparam logic [3:0] c_fdc_reg_msr  = 4'h4;
    localparam logic [3:0] c_fdc_reg_fifo = 4'h5;
    localparam logic [3:0] c_fdc_reg_dir  = 4'h7;

    // Clamp a timing parameter into its legal range and size it for a counter
    function automatic logic [c_cnt_w-1:0] clamp_cnt(input int value, input int lo, input int hi);
        int t;
        t = value;
        if (t < lo) t = lo;
        if (t > hi) t = hi;
        return c_cnt_w'(t);
    endfunction

endpackage
`default_nettype wire

// File: rtl/phi2_bus_responder_phi_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : phi_edge_detect
// Description : Registers a clock-generator phase signal once and reports
//               its rising and falling edges in the fpga_clk domain. The
//               phase is already synchronous, so no synchroniser is needed.
// Revision    : 1.0 - initial release
// ============================================================================
module phi_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic sig_q;

    // Previous-cycle copy of the phase, cleared to low by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= i_sig;
        end
    end

    assign o_rise = i_sig & ~sig_q;
    assign o_fall = ~i_sig & sig_q;

endmodule
`default_nettype wire

// File: rtl/phi2_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : phi2_bus_responder
// Description : Decodes 6502-style bus cycles framed by phi_2 into single
//               cycle read/write strobes for the FDC core, drives read data
//               back onto the CPU bus and flags reads that ran out of time.
// Revision    : 1.0 - initial release
// ============================================================================
module phi2_bus_responder
    import phi2_bus_responder_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int RD_LATENCY  = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic              fpga_clk,
    input  logic              reset,
    input  logic              phi_2,
    input  logic              cs_n,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              data_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    output logic              late_rd
);

    localparam logic [c_cnt_w-1:0] c_rd_latency =
        clamp_cnt(RD_LATENCY, c_rd_latency_min, c_rd_latency_max);
    localparam logic [c_cnt_w-1:0] c_hold_cycles =
        clamp_cnt(HOLD_CYCLES, c_hold_cycles_min, c_hold_cycles_max);

    logic w_rise;
    logic w_fall;

    bus_state_e           state_q,     state_d;
    logic [c_cnt_w-1:0]   lat_cnt_q,   lat_cnt_d;
    logic [c_cnt_w-1:0]   hold_cnt_q,  hold_cnt_d;
    logic [7:0]           data_out_q,  data_out_d;
    logic                 data_oe_q,   data_oe_d;
    logic [ADDR_W-1:0]    reg_addr_q,  reg_addr_d;
    logic [7:0]           reg_wdata_q, reg_wdata_d;
    logic                 reg_wr_q,    reg_wr_d;
    logic                 reg_rd_q,    reg_rd_d;
    logic                 late_rd_q,   late_rd_d;

    phi_edge_detect u_phi2_edge (
        .clk    (fpga_clk),
        .rst_n  (reset),
        .i_sig  (phi_2),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // Next-state and next-output logic for one bus cycle
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        data_out_d  = data_out_q;
        data_oe_d   = data_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;
        late_rd_d   = late_rd_q;

        unique case (state_q)
            ST_IDLE: begin
                // New cycles are started by the shared rise handling below
            end
            ST_RD_WAIT: begin
                if (w_fall) begin
                    // CPU is done: take whatever the core presents now.
                    // A fall on the capture cycle itself is still on time.
                    data_out_d = reg_rdata;
                    lat_cnt_d  = '0;
                    if (lat_cnt_q != c_cnt_w'(1)) late_rd_d = 1'b1;
                    if (c_hold_cycles == '0) begin
                        data_oe_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        hold_cnt_d = c_hold_cycles;
                        state_d    = ST_HOLD;
                    end
                end else if (lat_cnt_q == c_cnt_w'(1)) begin
                    data_out_d = reg_rdata;
                    lat_cnt_d  = '0;
                    state_d    = ST_RD_DRIVE;
                end else begin
                    lat_cnt_d = lat_cnt_q - c_cnt_w'(1);
                end
            end
            ST_RD_DRIVE: begin
                if (w_fall) begin
                    if (c_hold_cycles == '0) begin
                        data_oe_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        hold_cnt_d = c_hold_cycles;
                        state_d    = ST_HOLD;
                    end
                end
            end
            ST_WR_WAIT: begin
                if (w_fall) begin
                    reg_wdata_d = data_in;
                    reg_wr_d    = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q <= c_cnt_w'(1)) begin
                    hold_cnt_d = '0;
                    data_oe_d  = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - c_cnt_w'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                data_oe_d = 1'b0;
            end
        endcase

        // A rise while idle or holding starts a new cycle; holding ends at once
        if (w_rise && (state_q == ST_IDLE || state_q == ST_HOLD)) begin
            state_d    = ST_IDLE;
            data_oe_d  = 1'b0;
            hold_cnt_d = '0;
            if (!cs_n) begin
                reg_addr_d = addr;
                if (rw) begin
                    state_d   = ST_RD_WAIT;
                    reg_rd_d  = 1'b1;
                    data_oe_d = 1'b1;
                    lat_cnt_d = c_rd_latency;
                end else begin
                    state_d = ST_WR_WAIT;
                end
            end
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge fpga_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            data_out_q  <= '0;
            data_oe_q   <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            late_rd_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            late_rd_q   <= late_rd_d;
        end
    end

    assign data_out  = data_out_q;
    assign data_oe   = data_oe_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_wr    = reg_wr_q;
    assign reg_rd    = reg_rd_q;
    assign late_rd   = late_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_phi2_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_phi2_bus_responder
// Description : Self-checking bench. Three responders with different read
//               latency / hold settings share one CPU bus; a bus-cycle level
//               model predicts every output each cycle, and directed cycles
//               pin the model with hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phi2_bus_responder;

    localparam int c_n = 3;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 15;
            default: return 3;
        endcase
    endfunction

    function automatic int hold_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 15;
        endcase
    endfunction

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       phi_2 = 1'b0;
    logic       cs_n  = 1'b1;
    logic       rw    = 1'b0;
    logic [3:0] addr  = 4'h0;
    logic [7:0] data_in = 8'h00;
    logic       fix_rdata = 1'b1;

    logic [7:0] rdata [c_n];
    logic [7:0] dout  [c_n];
    logic       oe    [c_n];
    logic [3:0] raddr [c_n];
    logic [7:0] wdata [c_n];
    logic       wr    [c_n];
    logic       rd    [c_n];
    logic       late  [c_n];

    int n_total = 0;
    int n_pass  = 0;
    int pin_mode = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < c_n; gi++) begin : g_dut
        phi2_bus_responder #(
            .ADDR_W      (4),
            .RD_LATENCY  (lat_of(gi)),
            .HOLD_CYCLES (hold_of(gi))
        ) u_dut (
            .fpga_clk  (clk),
            .reset     (rst_n),
            .phi_2     (phi_2),
            .cs_n      (cs_n),
            .rw        (rw),
            .addr      (addr),
            .data_in   (data_in),
            .data_out  (dout[gi]),
            .data_oe   (oe[gi]),
            .reg_addr  (raddr[gi]),
            .reg_wdata (wdata[gi]),
            .reg_wr    (wr[gi]),
            .reg_rd    (rd[gi]),
            .reg_rdata (rdata[gi]),
            .late_rd   (late[gi])
        );
    end

    // FDC core stand-in: read data changes every cycle unless pinned
    always @(negedge clk) begin
        for (int i = 0; i < c_n; i++) begin
            rdata[i] = fix_rdata ? 8'hA5 : 8'($urandom);
        end
    end

    // ------------------------------------------------------------------
    // Bus-cycle model: tracks when each pending event is due by cycle number
    // ------------------------------------------------------------------
    int         cyc = 0;
    logic       phi_prev;
    logic [7:0] m_dout  [c_n];
    logic       m_oe    [c_n];
    logic [3:0] m_addr  [c_n];
    logic [7:0] m_wdata [c_n];
    logic       m_wr    [c_n];
    logic       m_rd    [c_n];
    logic       m_late  [c_n];
    bit         rd_pend [c_n];   // read issued, data not yet captured
    bit         rd_have [c_n];   // data captured, waiting for phi_2 fall
    bit         wr_pend [c_n];
    bit         hold_on [c_n];
    int         cap_at  [c_n];
    int         off_at  [c_n];

    always @(posedge clk or negedge rst_n) begin
        bit rise, fall;
        if (!rst_n) begin
            phi_prev = 1'b0;
            for (int i = 0; i < c_n; i++) begin
                m_dout[i] = 8'h00; m_oe[i] = 1'b0; m_addr[i] = 4'h0; m_wdata[i] = 8'h00;
                m_wr[i] = 1'b0; m_rd[i] = 1'b0; m_late[i] = 1'b0;
                rd_pend[i] = 0; rd_have[i] = 0; wr_pend[i] = 0; hold_on[i] = 0;
            end
        end else begin
            cyc++;
            rise = phi_2 && !phi_prev;
            fall = !phi_2 && phi_prev;
            phi_prev = phi_2;
            for (int i = 0; i < c_n; i++) begin
                m_wr[i] = 1'b0;
                m_rd[i] = 1'b0;
                if (rise) begin
                    if (hold_on[i]) begin hold_on[i] = 0; m_oe[i] = 1'b0; end
                    if (!cs_n) begin
                        m_addr[i] = addr;
                        if (rw) begin
                            rd_pend[i] = 1; m_rd[i] = 1'b1; m_oe[i] = 1'b1;
                            cap_at[i] = cyc + lat_of(i);
                        end else begin
                            wr_pend[i] = 1;
                        end
                    end
                end else if (fall) begin
                    if (wr_pend[i]) begin
                        m_wdata[i] = data_in; m_wr[i] = 1'b1; wr_pend[i] = 0;
                    end
                    if (rd_pend[i] || rd_have[i]) begin
                        if (rd_pend[i]) begin
                            m_dout[i] = rdata[i];
                            if (cyc < cap_at[i]) m_late[i] = 1'b1;
                        end
                        rd_pend[i] = 0; rd_have[i] = 0;
                        if (hold_of(i) == 0) m_oe[i] = 1'b0;
                        else begin hold_on[i] = 1; off_at[i] = cyc + hold_of(i); end
                    end
                end else begin
                    if (rd_pend[i] && cyc == cap_at[i]) begin
                        m_dout[i] = rdata[i]; rd_pend[i] = 0; rd_have[i] = 1;
                    end
                    if (hold_on[i] && cyc == off_at[i]) begin
                        m_oe[i] = 1'b0; hold_on[i] = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d] at cycle %0d: got %0h, expected %0h", name, idx, cyc, act, exp);
    endtask

    // Per-cycle compare against the model
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < c_n; i++) begin
            chk("data_oe",   i, 8'(oe[i]),    8'(m_oe[i]));
            chk("reg_addr",  i, 8'(raddr[i]), 8'(m_addr[i]));
            chk("reg_wdata", i, wdata[i],     m_wdata[i]);
            chk("reg_wr",    i, 8'(wr[i]),    8'(m_wr[i]));
            chk("reg_rd",    i, 8'(rd[i]),    8'(m_rd[i]));
            chk("late_rd",   i, 8'(late[i]),  8'(m_late[i]));
            if (m_oe[i]) chk("data_out", i, dout[i], m_dout[i]);
        end
    end

    // Hand-computed expectations for the directed cycles.
    // ph: 0 = k-th edge after phi_2 rose, 1 = k-th edge after it fell, 2 = just after reset assert
    task automatic pin(input int ph, input int k);
        case (pin_mode)
            1: begin
                if (ph == 0 && k == 1) begin chk("rd_pulse", 0, 8'(rd[0]), 8'h01); chk("rd_addr", 0, 8'(raddr[0]), 8'h03); end
                if (ph == 0 && k == 2) chk("rd_single", 0, 8'(rd[0]), 8'h00);
                if (ph == 0 && k == 3) begin chk("rd_dout_early", 0, dout[0], 8'hA5); chk("rd_oe", 0, 8'(oe[0]), 8'h01); end
                if (ph == 1 && k == 1) begin chk("rd_dout_fall", 0, dout[0], 8'hA5); chk("rd_oe_fall", 0, 8'(oe[0]), 8'h01); end
                if (ph == 1 && k == 2) chk("rd_oe_drop", 0, 8'(oe[0]), 8'h00);
            end
            2: begin
                if (ph == 0 && k == 3) begin chk("wr_oe_high", 0, 8'(oe[0]), 8'h00); chk("wr_early", 0, 8'(wr[0]), 8'h00); end
                if (ph == 1 && k == 1) begin
                    chk("wr_pulse", 0, 8'(wr[0]), 8'h01);
                    chk("wr_data",  0, wdata[0],  8'h5C);
                    chk("wr_addr",  0, 8'(raddr[0]), 8'h07);
                    chk("wr_oe",    0, 8'(oe[0]), 8'h00);
                end
                if (ph == 1 && k == 2) chk("wr_single", 0, 8'(wr[0]), 8'h00);
            end
            3: begin
                if (ph == 0 && k == 1) begin chk("nocs_rd", 0, 8'(rd[0]), 8'h00); chk("nocs_oe", 0, 8'(oe[0]), 8'h00); end
                if (ph == 1 && k == 1) chk("nocs_wr", 0, 8'(wr[0]), 8'h00);
            end
            4: begin
                if (ph == 0 && k == 9) chk("late_pre", 1, 8'(late[1]), 8'h00);
                if (ph == 1 && k == 1) begin
                    chk("late_set",  1, 8'(late[1]), 8'h01);
                    chk("late_dout", 1, dout[1], rdata[1]);
                    chk("late_oe",   1, 8'(oe[1]), 8'h00);
                end
            end
            5: begin
                if (ph == 1 && k == 1) chk("late_sticky", 1, 8'(late[1]), 8'h01);
            end
            6: begin
                if (ph == 2) begin
                    chk("rst_wr",   0, 8'(wr[0]), 8'h00);
                    chk("rst_addr", 0, 8'(raddr[0]), 8'h00);
                    chk("rst_oe",   0, 8'(oe[0]), 8'h00);
                    chk("rst_late", 1, 8'(late[1]), 8'h00);
                end
                if (ph == 1 && (k == 1 || k == 2)) chk("rst_no_wr", 0, 8'(wr[0]), 8'h00);
            end
            7: begin
                if (ph == 1 && (k == 5 || k == 10)) chk("hold_oe", 2, 8'(oe[2]), 8'h01);
            end
            8: begin
                if (ph == 0 && k == 1) begin chk("b2b_oe", 2, 8'(oe[2]), 8'h00); chk("b2b_addr", 2, 8'(raddr[2]), 8'h0B); end
                if (ph == 1 && k == 1) chk("b2b_wr", 2, 8'(wr[2]), 8'h01);
            end
            default: ;
        endcase
    endtask

    // One phi_2 period: high for hi edges, low for lo edges
    task automatic run_cycle(input int hi, input int lo, input logic c, input logic r,
                             input logic [3:0] a, input logic [7:0] d, input int rst_k);
        @(negedge clk);
        phi_2 = 1'b1; cs_n = c; rw = r; addr = a; data_in = d;
        for (int k = 1; k <= hi; k++) begin
            @(posedge clk);
            #1;
            pin(0, k);
            if (k == 1) begin cs_n = 1'($urandom); rw = 1'($urandom); addr = 4'($urandom); end
            if (k == rst_k) begin rst_n = 1'b0; #1; pin(2, 0); end
        end
        @(negedge clk);
        phi_2 = 1'b0;
        for (int k = 1; k <= lo; k++) begin
            @(posedge clk);
            #1;
            pin(1, k);
            if (k == 1) begin data_in = 8'($urandom); rst_n = 1'b1; end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < c_n; i++) begin
            chk("reset_oe",   i, 8'(oe[i]),    8'h00);
            chk("reset_dout", i, dout[i],      8'h00);
            chk("reset_rd",   i, 8'(rd[i]),    8'h00);
            chk("reset_wr",   i, 8'(wr[i]),    8'h00);
            chk("reset_late", i, 8'(late[i]),  8'h00);
            chk("reset_addr", i, 8'(raddr[i]), 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        pin_mode = 1; run_cycle(25, 25, 1'b0, 1'b1, 4'h3, 8'h00, 0);
        pin_mode = 2; run_cycle(25, 25, 1'b0, 1'b0, 4'h7, 8'h5C, 0);
        pin_mode = 3; run_cycle(25, 25, 1'b1, 1'b1, 4'h2, 8'h11, 0);
        fix_rdata = 1'b0;
        pin_mode = 4; run_cycle(10, 25, 1'b0, 1'b1, 4'h4, 8'h00, 0);
        pin_mode = 5; run_cycle(25, 25, 1'b0, 1'b1, 4'h5, 8'h00, 0);
        pin_mode = 6; run_cycle(25, 25, 1'b0, 1'b0, 4'h7, 8'h3C, 20);
        pin_mode = 7; run_cycle(20, 10, 1'b0, 1'b1, 4'h6, 8'h00, 0);
        pin_mode = 8; run_cycle(20, 20, 1'b0, 1'b0, 4'hB, 8'h99, 0);

        pin_mode = 0;
        for (int n = 0; n < 80; n++) begin
            run_cycle(int'($urandom_range(1, 30)), int'($urandom_range(1, 30)),
                      ($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom), 8'($urandom), 0);
        end
        repeat (5) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
